multiword_adder: RTL and testbench

MULTIWORD_ADDER -- requirements
Module: multiword_adder

---
 rtl/multiword_adder.sv | 181 ++++++++++++++++++
 tb/tb_multiword_adder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_adder.sv
// Multi-word adder: adds two N*WORDS-bit unsigned operands plus a carry-in
// by streaming one N-bit chunk per clock through a single N-bit adder,
// least-significant chunk first, with the carry held in a register between
// chunks. The result is published only once the final chunk is done.

// Plain N-bit ripple adder with carry in and carry out.
module adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);

    // Full-width add; the bit above the chunk is the carry out.
    always_comb begin
        {Cout, S} = {1'b0, A} + {1'b0, B} + {{N{1'b0}}, Cin};
    end

endmodule

module multiword_adder #(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [N*WORDS-1:0]   A,
    input  logic [N*WORDS-1:0]   B,
    input  logic                 Cin,
    output logic                 ready,
    output logic                 busy,
    output logic                 done,
    output logic [N*WORDS-1:0]   S,
    output logic                 Cout
);

    localparam int W  = N * WORDS;
    localparam int CW = $clog2(WORDS + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [W-1:0]    op_a;
    logic [W-1:0]    op_b;
    logic [W-1:0]    shadow;
    logic [W-1:0]    shadow_next;
    logic            carry;
    logic [CW-1:0]   cnt;
    logic            last_chunk;

    logic [N-1:0]    chunk_a;
    logic [N-1:0]    chunk_b;
    logic [N-1:0]    chunk_s;
    logic            chunk_cout;

    assign last_chunk = (cnt == CW'(WORDS - 1));

    // Select the operand chunks addressed by the chunk counter.
    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (cnt == CW'(i)) begin
                chunk_a = op_a[i*N +: N];
                chunk_b = op_b[i*N +: N];
            end
        end
    end

    adder #(
        .N(N)
    ) u_adder (
        .A    (chunk_a),
        .B    (chunk_b),
        .Cin  (carry),
        .S    (chunk_s),
        .Cout (chunk_cout)
    );

    // Shadow sum with the current chunk merged in, so the final edge can
    // publish the complete result including the chunk computed that cycle.
    always_comb begin
        shadow_next = shadow;
        for (int unsigned i = 0; i < WORDS; i++) begin
            if (cnt == CW'(i)) begin
                shadow_next[i*N +: N] = chunk_s;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: IDLE waits for start, RUN walks the chunks, DONE lasts one cycle.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_chunk) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            IDLE:    ready = 1'b1;
            RUN:     busy  = 1'b1;
            DONE:    done  = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Datapath: capture operands on accept, accumulate chunks in RUN, publish at the end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a   <= '0;
            op_b   <= '0;
            shadow <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            S      <= '0;
            Cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a  <= A;
                        op_b  <= B;
                        carry <= Cin;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    shadow <= shadow_next;
                    carry  <= chunk_cout;
                    cnt    <= cnt + CW'(1);
                    if (last_chunk) begin
                        S    <= shadow_next;
                        Cout <= chunk_cout;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_adder.sv
// Self-checking bench for multiword_adder: directed corner cases, randomized
// operations against an arithmetic reference, reset abort, and a width sweep.
module tb_multiword_adder;

    localparam int N     = 8;
    localparam int WORDS = 4;
    localparam int W     = N * WORDS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          cin;
    logic          ready;
    logic          busy;
    logic          done;
    logic [W-1:0]  s;
    logic          cout;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multiword_adder #(
        .N     (N),
        .WORDS (WORDS)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a),
        .B     (b),
        .Cin   (cin),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .S     (s),
        .Cout  (cout)
    );

    // Width-sweep instances share rst and one start line.
    logic        start_sw;
    logic        cin_sw;
    logic [0:0]  a1, b1, s1;
    logic [3:0]  a2, b2, s2;
    logic [63:0] a3, b3, s3;
    logic [63:0] a4, b4, s4;
    logic        rdy1, bsy1, dn1, co1;
    logic        rdy2, bsy2, dn2, co2;
    logic        rdy3, bsy3, dn3, co3;
    logic        rdy4, bsy4, dn4, co4;

    multiword_adder #(.N(1), .WORDS(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start_sw), .A(a1), .B(b1), .Cin(cin_sw),
        .ready(rdy1), .busy(bsy1), .done(dn1), .S(s1), .Cout(co1));
    multiword_adder #(.N(2), .WORDS(2)) u_w2 (
        .clk(clk), .rst(rst), .start(start_sw), .A(a2), .B(b2), .Cin(cin_sw),
        .ready(rdy2), .busy(bsy2), .done(dn2), .S(s2), .Cout(co2));
    multiword_adder #(.N(8), .WORDS(8)) u_w3 (
        .clk(clk), .rst(rst), .start(start_sw), .A(a3), .B(b3), .Cin(cin_sw),
        .ready(rdy3), .busy(bsy3), .done(dn3), .S(s3), .Cout(co3));
    multiword_adder #(.N(16), .WORDS(4)) u_w4 (
        .clk(clk), .rst(rst), .start(start_sw), .A(a4), .B(b4), .Cin(cin_sw),
        .ready(rdy4), .busy(bsy4), .done(dn4), .S(s4), .Cout(co4));

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One operation from IDLE. mode: 0 keep inputs, 1 drive all-ones after
    // acceptance, 2 drive random junk every cycle after acceptance.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input bit hold, input int mode,
                          input string tag);
        logic [W:0]   expected;
        logic [W-1:0] prev_s;
        logic         prev_c;
        expected = {1'b0, ta} + {1'b0, tb} + {{W{1'b0}}, tc};
        prev_s   = s;
        prev_c   = cout;
        check({tag, ".ready_before"}, ready, 1);
        a     = ta;
        b     = tb;
        cin   = tc;
        start = 1'b1;
        step();                                  // edge k: accepted
        if (!hold) start = 1'b0;
        for (int i = 1; i <= WORDS; i++) begin
            if (mode == 1) begin
                a = '1;
                b = '1;
            end else if (mode == 2) begin
                a   = $urandom;
                b   = $urandom;
                cin = 1'($urandom);
            end
            step();                              // edge k+i
            if (i < WORDS) begin
                check({tag, ".busy"}, busy, 1);
                check({tag, ".done_early"}, done, 0);
                check({tag, ".s_hold"}, s, prev_s);
                check({tag, ".cout_hold"}, cout, prev_c);
            end else begin
                check({tag, ".done"}, done, 1);
                check({tag, ".ready_in_done"}, ready, 0);
                check({tag, ".s"}, s, expected[W-1:0]);
                check({tag, ".cout"}, cout, expected[W]);
            end
        end
        step();                                  // edge k+WORDS+1
        check({tag, ".done_single"}, done, 0);
        check({tag, ".ready_back"}, ready, 1);
        start = 1'b0;
        step();
        check({tag, ".no_second_done"}, done, 0);
        check({tag, ".idle_busy"}, busy, 0);
        check({tag, ".s_kept"}, s, expected[W-1:0]);
    endtask

    initial begin
        int dc1, dc2, dc3, dc4;
        rst      = 1'b1;
        start    = 1'b1;
        a        = 32'h1234_5678;
        b        = 32'h9abc_def0;
        cin      = 1'b1;
        start_sw = 1'b0;
        cin_sw   = 1'b0;
        a1 = '0; b1 = '0; a2 = '0; b2 = '0;
        a3 = '0; b3 = '0; a4 = '0; b4 = '0;

        // Reset values before any clock edge, with start held high.
        #2;
        check("rst.s", s, 0);
        check("rst.cout", cout, 0);
        check("rst.ready", ready, 1);
        check("rst.busy", busy, 0);
        check("rst.done", done, 0);
        step();
        step();
        check("rst.start_ignored_busy", busy, 0);
        check("rst.start_ignored_ready", ready, 1);
        start = 1'b0;
        rst   = 1'b0;
        step();
        step();
        check("idle.ready", ready, 1);
        check("idle.busy", busy, 0);
        check("idle.s", s, 0);

        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0, "ripple");
        run_op(32'h0FFF_0FFF, 32'h0001_0001, 1'b1, 1'b1, 0, "carry_in_hold");
        run_op(32'h0000_0078, 32'h0000_0082, 1'b0, 1'b0, 1, "operand_change");

        // Reset in the middle of an operation.
        a     = 32'hDEAD_BEEF;
        b     = 32'h1111_1111;
        cin   = 1'b0;
        start = 1'b1;
        step();                                  // edge k
        start = 1'b0;
        step();                                  // edge k+1
        @(posedge clk);                          // edge k+2
        rst = 1'b1;
        #1;
        check("abort.s", s, 0);
        check("abort.cout", cout, 0);
        check("abort.ready", ready, 1);
        check("abort.busy", busy, 0);
        check("abort.done", done, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort.no_done", done, 0);
        end
        rst = 1'b0;
        step();
        check("abort.s_after", s, 0);
        run_op(32'd5, 32'd7, 1'b1, 1'b0, 0, "after_abort");

        // Randomized operations against the arithmetic reference.
        for (int n = 0; n < 16; n++) begin
            run_op($urandom, $urandom, 1'($urandom), 1'($urandom), 2, "random");
        end

        // Width sweep: all-ones + 1 + 1 wraps to 1 with a carry out.
        a1 = '1; b1 = 1'b1;
        a2 = '1; b2 = 4'd1;
        a3 = '1; b3 = 64'd1;
        a4 = '1; b4 = 64'd1;
        cin_sw   = 1'b1;
        start_sw = 1'b1;
        step();                                  // edge k
        start_sw = 1'b0;
        dc1 = -1; dc2 = -1; dc3 = -1; dc4 = -1;
        for (int c = 1; c <= 12; c++) begin
            step();
            if (dn1 && dc1 < 0) dc1 = c;
            if (dn2 && dc2 < 0) dc2 = c;
            if (dn3 && dc3 < 0) dc3 = c;
            if (dn4 && dc4 < 0) dc4 = c;
        end
        check("sweep1.latency", 65'(dc1), 1);
        check("sweep2.latency", 65'(dc2), 2);
        check("sweep3.latency", 65'(dc3), 8);
        check("sweep4.latency", 65'(dc4), 4);
        check("sweep1.s", s1, 1);
        check("sweep2.s", s2, 1);
        check("sweep3.s", s3, 1);
        check("sweep4.s", s4, 1);
        check("sweep1.cout", co1, 1);
        check("sweep2.cout", co2, 1);
        check("sweep3.cout", co3, 1);
        check("sweep4.cout", co4, 1);
        check("sweep.ready", {rdy1, rdy2, rdy3, rdy4}, 4'hF);
        check("sweep.busy", {bsy1, bsy2, bsy3, bsy4}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
